// File: rtl/video_test_pattern_generator_if.sv
// rtl/video_test_pattern_generator_if.sv - raster timing into the pattern generator, RGB pixels with sync out
interface video_test_pattern_generator_if #(
    parameter int COLOR_BITS = 8,
    parameter int POS_BITS   = 11
);
    logic                  data_enable_in;
    logic                  h_sync_in;
    logic                  v_sync_in;
    logic [POS_BITS-1:0]   h_pos;
    logic [POS_BITS-1:0]   v_pos;
    logic                  data_enable;
    logic                  h_sync;
    logic                  v_sync;
    logic [COLOR_BITS-1:0] red;
    logic [COLOR_BITS-1:0] green;
    logic [COLOR_BITS-1:0] blue;

    modport master (
        output data_enable_in, h_sync_in, v_sync_in, h_pos, v_pos,
        input  data_enable, h_sync, v_sync, red, green, blue
    );

    modport slave (
        input  data_enable_in, h_sync_in, v_sync_in, h_pos, v_pos,
        output data_enable, h_sync, v_sync, red, green, blue
    );
endinterface

// File: rtl/video_test_pattern_generator.sv
// rtl/video_test_pattern_generator.sv - run-time selectable test patterns, 2-clock latency, optional TEST_PATTERN_BORDER_EN frame border
module video_test_pattern_generator #(
    parameter int COLOR_BITS   = 8,
    parameter int POS_BITS     = 11,
    parameter int CHECKER_LOG2 = 5,
    parameter int MOVE_STEP    = 4,
    parameter int MOVE_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    video_test_pattern_generator_if.slave vid,
    input  logic [POS_BITS-1:0]   h_active,
    input  logic [POS_BITS-1:0]   v_active,
    input  logic [2:0]            mode,
    input  logic [COLOR_BITS-1:0] solid_red,
    input  logic [COLOR_BITS-1:0] solid_green,
    input  logic [COLOR_BITS-1:0] solid_blue,
    output logic [15:0]           frame_count
);
    localparam logic [COLOR_BITS-1:0] FULL = '1;

    // Stage-1 sync registers; vs_q also serves as the registered vsync for frame detection.
    logic                  de_q;
    logic                  hs_q;
    logic                  vs_q;
    logic [COLOR_BITS-1:0] r_q;
    logic [COLOR_BITS-1:0] g_q;
    logic [COLOR_BITS-1:0] b_q;

    logic [2:0]            active_mode;
    logic [POS_BITS-1:0]   move_pos;
    logic [POS_BITS-1:0]   bar_cnt;
    logic [2:0]            bar_idx;

    logic                  frame_event;
    logic                  line_start;
    logic [POS_BITS-1:0]   bar_last;
    logic [POS_BITS-1:0]   cnt_cur;
    logic [2:0]            idx_cur;
    logic [POS_BITS:0]     move_sum;
    logic [POS_BITS:0]     move_end;
    logic                  in_move_bar;
    logic                  checker_on;
    logic [COLOR_BITS-1:0] pix_r;
    logic [COLOR_BITS-1:0] pix_g;
    logic [COLOR_BITS-1:0] pix_b;

    assign frame_event = vid.v_sync_in & ~vs_q;
    assign line_start  = vid.data_enable_in & ~de_q;
    assign bar_last    = (h_active >> 3) - 1'b1;
    assign cnt_cur     = line_start ? '0 : bar_cnt;
    assign idx_cur     = line_start ? 3'd0 : bar_idx;
    assign move_sum    = {1'b0, move_pos} + (POS_BITS+1)'(MOVE_STEP);
    assign move_end    = {1'b0, move_pos} + (POS_BITS+1)'(MOVE_WIDTH);
    assign in_move_bar = (vid.h_pos >= move_pos) && ({1'b0, vid.h_pos} < move_end);
    assign checker_on  = vid.h_pos[CHECKER_LOG2] ^ vid.v_pos[CHECKER_LOG2];

    always_comb begin
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        case (active_mode)
            3'd0: begin
                pix_r = solid_red;
                pix_g = solid_green;
                pix_b = solid_blue;
            end
            3'd1: begin
                // white, yellow, cyan, green, magenta, red, blue, black
                pix_r = {COLOR_BITS{~idx_cur[1]}};
                pix_g = {COLOR_BITS{~idx_cur[2]}};
                pix_b = {COLOR_BITS{~idx_cur[0]}};
            end
            3'd2: begin
                pix_r = {COLOR_BITS{checker_on}};
                pix_g = {COLOR_BITS{checker_on}};
                pix_b = {COLOR_BITS{checker_on}};
            end
            3'd3: begin
                pix_r = vid.h_pos[COLOR_BITS-1:0];
                pix_g = vid.h_pos[COLOR_BITS-1:0];
                pix_b = vid.h_pos[COLOR_BITS-1:0];
            end
            3'd4: begin
                pix_r = {COLOR_BITS{in_move_bar}};
                pix_g = {COLOR_BITS{in_move_bar}};
                pix_b = {COLOR_BITS{in_move_bar}};
            end
            default: ;
        endcase
`ifdef TEST_PATTERN_BORDER_EN
        if (vid.data_enable_in && (vid.h_pos == '0 || vid.h_pos == h_active - 1'b1 ||
                                   vid.v_pos == '0 || vid.v_pos == v_active - 1'b1)) begin
            pix_r = FULL;
            pix_g = FULL;
            pix_b = FULL;
        end
`endif
    end

`ifndef TEST_PATTERN_BORDER_EN
    logic unused_inputs;
    assign unused_inputs = ^{v_active, vid.v_pos, FULL};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_q            <= 1'b0;
            hs_q            <= 1'b0;
            vs_q            <= 1'b0;
            r_q             <= '0;
            g_q             <= '0;
            b_q             <= '0;
            vid.data_enable <= 1'b0;
            vid.h_sync      <= 1'b0;
            vid.v_sync      <= 1'b0;
            vid.red         <= '0;
            vid.green       <= '0;
            vid.blue        <= '0;
            active_mode     <= 3'd0;
            move_pos        <= '0;
            bar_cnt         <= '0;
            bar_idx         <= 3'd0;
            frame_count     <= 16'd0;
        end else begin
            de_q            <= vid.data_enable_in;
            hs_q            <= vid.h_sync_in;
            vs_q            <= vid.v_sync_in;
            // Blanking is applied here; the second stage only delays it.
            r_q             <= vid.data_enable_in ? pix_r : '0;
            g_q             <= vid.data_enable_in ? pix_g : '0;
            b_q             <= vid.data_enable_in ? pix_b : '0;
            vid.data_enable <= de_q;
            vid.h_sync      <= hs_q;
            vid.v_sync      <= vs_q;
            vid.red         <= r_q;
            vid.green       <= g_q;
            vid.blue        <= b_q;

            if (vid.data_enable_in) begin
                if (cnt_cur == bar_last) begin
                    bar_cnt <= '0;
                    bar_idx <= (idx_cur == 3'd7) ? 3'd7 : idx_cur + 3'd1;
                end else begin
                    bar_cnt <= cnt_cur + 1'b1;
                    bar_idx <= idx_cur;
                end
            end

            if (frame_event) begin
                active_mode <= mode;
                frame_count <= frame_count + 16'd1;
                move_pos    <= (move_sum >= {1'b0, h_active}) ? '0 : move_sum[POS_BITS-1:0];
            end
        end
    end
endmodule

// File: tb/tb_video_test_pattern_generator.sv
// tb/tb_video_test_pattern_generator.sv - randomized raster stimulus checked against a per-pixel pattern model
module tb_video_test_pattern_generator;
    localparam int CB = 8;
    localparam int PB = 11;
    localparam int CL = 5;
    localparam int MS = 4;
    localparam int MW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [PB-1:0] h_active;
    logic [PB-1:0] v_active;
    logic [2:0]    mode;
    logic [CB-1:0] solid_red;
    logic [CB-1:0] solid_green;
    logic [CB-1:0] solid_blue;
    logic [15:0]   frame_count;

    always #5 clk = ~clk;

    video_test_pattern_generator_if #(.COLOR_BITS(CB), .POS_BITS(PB)) vid ();

    video_test_pattern_generator #(
        .COLOR_BITS(CB), .POS_BITS(PB), .CHECKER_LOG2(CL), .MOVE_STEP(MS), .MOVE_WIDTH(MW)
    ) dut (
        .clk(clk), .rst(rst), .vid(vid),
        .h_active(h_active), .v_active(v_active), .mode(mode),
        .solid_red(solid_red), .solid_green(solid_green), .solid_blue(solid_blue),
        .frame_count(frame_count)
    );

    int          total = 0;
    int          bad = 0;
    int          m_mode;
    int          m_frames;
    int          m_move;
    bit          m_prev_vs;
    logic [31:0] exp_prev;
    string       tag_prev;
    int          rows[$];
    logic [2:0]  bar_rgb [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] observed();
        return {5'b0, vid.data_enable, vid.h_sync, vid.v_sync, vid.red, vid.green, vid.blue};
    endfunction

    function automatic string mode_tag(input bit de);
        if (!de) return "blank";
        case (m_mode)
            0: return "solid";
            1: return "bars";
            2: return "checker";
            3: return "gradient";
            4: return "move_bar";
            default: return "reserved";
        endcase
    endfunction

    function automatic logic [31:0] model_pixel(input bit de, input bit hs, input bit vs, input int hp, input int vp);
        int r = 0, g = 0, b = 0;
        int bw, bi;
        if (de) begin
            case (m_mode)
                0: begin r = solid_red; g = solid_green; b = solid_blue; end
                1: begin
                    bw = int'(h_active) / 8;
                    bi = hp / bw;
                    if (bi > 7) bi = 7;
                    r = bar_rgb[bi][2] ? 255 : 0;
                    g = bar_rgb[bi][1] ? 255 : 0;
                    b = bar_rgb[bi][0] ? 255 : 0;
                end
                2: if ((((hp >> CL) ^ (vp >> CL)) & 1) == 1) begin r = 255; g = 255; b = 255; end
                3: begin r = hp % 256; g = r; b = r; end
                4: if (hp >= m_move && hp < m_move + MW) begin r = 255; g = 255; b = 255; end
                default: ;
            endcase
`ifdef TEST_PATTERN_BORDER_EN
            if (hp == 0 || hp == int'(h_active) - 1 || vp == 0 || vp == int'(v_active) - 1) begin
                r = 255; g = 255; b = 255;
            end
`endif
        end
        return {5'b0, de, hs, vs, r[7:0], g[7:0], b[7:0]};
    endfunction

    task automatic model_reset();
        m_mode    = 0;
        m_frames  = 0;
        m_move    = 0;
        m_prev_vs = 1'b0;
        exp_prev  = '0;
        tag_prev  = "post_reset";
    endtask

    // One pixel clock: drive inputs, advance the model, compare the previous pixel's output.
    task automatic cycle(input bit de, input bit hs, input bit vs, input int hp, input int vp);
        logic [31:0] e;
        string       t;
        bit          fe;
        vid.data_enable_in = de;
        vid.h_sync_in      = hs;
        vid.v_sync_in      = vs;
        vid.h_pos          = hp[PB-1:0];
        vid.v_pos          = vp[PB-1:0];
        e  = model_pixel(de, hs, vs, hp, vp);
        t  = mode_tag(de);
        fe = vs && !m_prev_vs;
        if (fe) begin
            m_mode   = int'(mode);
            m_frames = (m_frames + 1) % 65536;
            m_move   = m_move + MS;
            if (m_move >= int'(h_active)) m_move = 0;
        end
        m_prev_vs = vs;
        @(posedge clk);
        #1;
        check_eq(tag_prev, observed(), exp_prev);
        if (fe) check_eq("frame_count", {16'd0, frame_count}, m_frames);
        exp_prev = e;
        tag_prev = t;
    endtask

    task automatic blank_cycle(input bit hs, input bit vs);
        cycle(1'b0, hs, vs, $urandom_range(0, 2047), $urandom_range(0, 2047));
    endtask

    task automatic line(input int hact, input int vp, input int hbl);
        repeat (2) blank_cycle(1'b1, 1'b0);
        repeat (hbl) blank_cycle(1'b0, 1'b0);
        for (int x = 0; x < hact; x++) cycle(1'b1, 1'b0, 1'b0, x, vp);
        repeat (2) blank_cycle(1'b0, 1'b0);
    endtask

    task automatic frame(input int hact, input int nlines, input int switch_line, input logic [2:0] switch_mode);
        h_active = hact[PB-1:0];
        repeat (3) blank_cycle(1'b0, 1'b1);
        repeat (2) blank_cycle(1'b0, 1'b0);
        for (int l = 0; l < nlines; l++) begin
            if (l == switch_line) mode = switch_mode;
            line(hact, (l < rows.size()) ? rows[l] : $urandom_range(0, 719), $urandom_range(4, 20));
        end
        repeat (2) blank_cycle(1'b0, 1'b0);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_eq("reset_pixel", observed(), 32'd0);
        check_eq("reset_frames", {16'd0, frame_count}, 32'd0);
        model_reset();
        @(posedge clk);
        #3 rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        vid.data_enable_in = 1'b0;
        vid.h_sync_in = 1'b0;
        vid.v_sync_in = 1'b0;
        vid.h_pos = '0;
        vid.v_pos = '0;
        h_active = 11'd1280;
        v_active = 11'd720;
        mode = 3'd0;
        solid_red = 8'd0;
        solid_green = 8'd255;
        solid_blue = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("init_pixel", observed(), 32'd0);
        check_eq("init_frames", {16'd0, frame_count}, 32'd0);
        #2 rst = 1'b0;
        model_reset();

        rows = '{0, 1, 719};
        frame(1280, 3, -1, 3'd0);

        mode = 3'd1;
        rows = '{10, 300};
        frame(1280, 2, -1, 3'd0);
        frame(1283, 2, -1, 3'd0);

        mode = 3'd2;
        rows = '{0, 32, 33, 64};
        frame(256, 4, -1, 3'd0);

        mode = 3'd0;
        solid_red = 8'($urandom);
        solid_green = 8'($urandom);
        solid_blue = 8'($urandom);
        rows = '{359, 360, 361};
        frame(1280, 3, 1, 3'd3);
        rows = '{0, 1};
        frame(600, 2, -1, 3'd0);

        mode = 3'd4;
        h_active = 11'd1280;
        for (int i = 0; i < 400 && m_move != 1272; i++) begin
            repeat (2) blank_cycle(1'b0, 1'b1);
            repeat (2) blank_cycle(1'b0, 1'b0);
        end
        rows = '{};
        repeat (3) frame(1280, 1, -1, 3'd0);

        mode = 3'd3;
        frame(300, 1, -1, 3'd0);
        repeat (2) blank_cycle(1'b1, 1'b0);
        for (int x = 0; x < 100; x++) cycle(1'b1, 1'b0, 1'b0, x, 5);
        async_reset();
        mode = 3'd2;
        repeat (4) blank_cycle(1'b0, 1'b0);
        line(300, 7, 6);
        frame(300, 1, -1, 3'd0);

        for (int i = 0; i < 5; i++) begin
            mode = (i == 0) ? 3'd6 : 3'($urandom_range(0, 7));
            solid_red = 8'($urandom);
            solid_green = 8'($urandom);
            solid_blue = 8'($urandom);
            frame($urandom_range(16, 400), 2, -1, 3'd0);
        end
        repeat (3) blank_cycle(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
